// File: rtl/accumulator_pipe.sv
// Pipelined N-lane reduction accumulator: registered adder tree feeding a
// per-packet accumulator with valid/ready handshakes, saturation and overflow.
module accumulator_pipe #(
  parameter int N        = 16,
  parameter int WIDTH    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1,
  parameter int GUARD    = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [N*WIDTH-1:0]   vals,
  output logic [WIDTH-1:0]     sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic                 ovf,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int LOG2N = $clog2(N);
  localparam int ACC_W = WIDTH + LOG2N + GUARD;
  // Tree nodes stored level by level: N leaves, N/2 sums, ..., 1 root.
  localparam int NODES = 2*N - 1;

  logic [ACC_W-1:0] r_tree [NODES];
  logic [ACC_W-1:0] w_next [NODES];
  logic [LOG2N:0]   r_vld;
  logic [LOG2N:0]   r_last;

  logic             w_stall;
  logic             w_accept;
  logic             r_sum_valid;

  assign w_stall  = !en || (r_sum_valid && !sum_ready);
  assign in_ready = !rst && !w_stall;
  assign w_accept = in_valid && in_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] w_lane;
    assign w_lane    = vals[N*WIDTH-1-i*WIDTH -: WIDTH];
    assign w_next[i] = {{(ACC_W-WIDTH){SIGNED & w_lane[WIDTH-1]}}, w_lane};
  end

  for (genvar k = 1; k <= LOG2N; k++) begin : g_level
    localparam int OFF  = 2*N - 2*(N >> k);
    localparam int PREV = 2*N - 2*(N >> (k-1));
    for (genvar i = 0; i < (N >> k); i++) begin : g_node
      assign w_next[OFF+i] = r_tree[PREV+2*i] + r_tree[PREV+2*i+1];
    end
  end

  // NOTE: the tree datapath has no reset; the valid bits alone qualify it,
  // so clearing wide data registers would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!w_stall) r_tree <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_last <= '0;
    end else if (!w_stall) begin
      r_vld  <= {r_vld[LOG2N-1:0], w_accept};
      r_last <= {r_last[LOG2N-1:0], in_last};
    end
  end

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_tree_vld;
  logic             w_tree_last;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf;
  logic [WIDTH-1:0] w_clamp;
  logic [WIDTH-1:0] w_sum;

  assign w_tree_vld  = r_vld[LOG2N];
  assign w_tree_last = r_last[LOG2N];
  assign w_acc_next  = (r_first ? '0 : r_acc) + r_tree[NODES-1];
  assign w_cnt_next  = r_first ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);

  if (SIGNED) begin : g_range_signed
    // In range when every bit from the WIDTH sign bit upward agrees.
    assign w_ovf   = !((&w_acc_next[ACC_W-1:WIDTH-1]) || !(|w_acc_next[ACC_W-1:WIDTH-1]));
    assign w_clamp = w_acc_next[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
  end else begin : g_range_unsigned
    assign w_ovf   = |w_acc_next[ACC_W-1:WIDTH];
    assign w_clamp = '1;
  end

  assign w_sum = (SATURATE && w_ovf) ? w_clamp : w_acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_beat_cnt  <= '0;
      r_sum_valid <= 1'b0;
    end else if (!w_stall) begin
      if (w_tree_vld) begin
        r_acc   <= w_acc_next;
        r_cnt   <= w_cnt_next;
        r_first <= w_tree_last;
      end
      if (w_tree_vld && w_tree_last) begin
        r_sum       <= w_sum;
        r_ovf       <= w_ovf;
        r_beat_cnt  <= w_cnt_next;
        r_sum_valid <= 1'b1;
      end else if (r_sum_valid && sum_ready) begin
        r_sum_valid <= 1'b0;
      end
    end
  end

  assign sum       = r_sum;
  assign ovf       = r_ovf;
  assign beat_cnt  = r_beat_cnt;
  assign sum_valid = r_sum_valid;

endmodule

// File: tb/tb_accumulator_pipe.sv
// Directed bench for accumulator_pipe: three parameter variants share one
// stimulus stream; a reference model fills per-variant scoreboards.
module tb_accumulator_pipe;

  localparam int N     = 16;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, in_valid, in_last, sum_ready;
  logic [WIDTH-1:0]   lanes [N];
  logic [N*WIDTH-1:0] vals;

  logic ss_ready, us_ready, uw_ready;
  logic [WIDTH-1:0] ss_sum, us_sum, uw_sum;
  logic ss_valid, us_valid, uw_valid;
  logic ss_ovf, us_ovf, uw_ovf;
  logic [CNT_W-1:0] ss_cnt, us_cnt, uw_cnt;

  exp_t q_ss[$], q_us[$], q_uw[$];
  longint m_acc_s, m_acc_u;
  int     m_cnt;
  int     n_total = 0;
  int     n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign vals[N*WIDTH-1-i*WIDTH -: WIDTH] = lanes[i];
  end

  accumulator_pipe #(.N(N), .WIDTH(WIDTH), .SIGNED(1'b1), .SATURATE(1'b1), .GUARD(8), .CNT_W(CNT_W)) u_ss (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ss_ready), .in_last(in_last),
    .vals(vals), .sum(ss_sum), .sum_valid(ss_valid), .sum_ready(sum_ready), .ovf(ss_ovf), .beat_cnt(ss_cnt));

  accumulator_pipe #(.N(N), .WIDTH(WIDTH), .SIGNED(1'b0), .SATURATE(1'b1), .GUARD(8), .CNT_W(CNT_W)) u_us (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(us_ready), .in_last(in_last),
    .vals(vals), .sum(us_sum), .sum_valid(us_valid), .sum_ready(sum_ready), .ovf(us_ovf), .beat_cnt(us_cnt));

  accumulator_pipe #(.N(N), .WIDTH(WIDTH), .SIGNED(1'b0), .SATURATE(1'b0), .GUARD(8), .CNT_W(CNT_W)) u_uw (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(uw_ready), .in_last(in_last),
    .vals(vals), .sum(uw_sum), .sum_valid(uw_valid), .sum_ready(sum_ready), .ovf(uw_ovf), .beat_cnt(uw_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic has, input exp_t e,
                           input logic [WIDTH-1:0] s, input logic o, input logic [CNT_W-1:0] c);
    check({tag, "_expected_pending"}, 64'(has), 64'd1);
    if (has) begin
      check({tag, "_sum"}, 64'(s), 64'(e.sum));
      check({tag, "_ovf"}, 64'(o), 64'(e.ovf));
      check({tag, "_beat_cnt"}, 64'(c), 64'(e.cnt));
    end
  endtask

  // Result consumed at the next rising edge: compare against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic has;
    if (!rst && en && sum_ready) begin
      if (ss_valid) begin
        has = (q_ss.size() > 0); e = '0;
        if (has) e = q_ss.pop_front();
        check_out("ss", has, e, ss_sum, ss_ovf, ss_cnt);
      end
      if (us_valid) begin
        has = (q_us.size() > 0); e = '0;
        if (has) e = q_us.pop_front();
        check_out("us", has, e, us_sum, us_ovf, us_cnt);
      end
      if (uw_valid) begin
        has = (q_uw.size() > 0); e = '0;
        if (has) e = q_uw.pop_front();
        check_out("uw", has, e, uw_sum, uw_ovf, uw_cnt);
      end
    end
  end

  task automatic model_clear();
    m_acc_s = 0;
    m_acc_u = 0;
    m_cnt   = 0;
  endtask

  task automatic model_accept(input logic last);
    exp_t   e;
    logic   o;
    logic [CNT_W-1:0] c;
    for (int i = 0; i < N; i++) begin
      m_acc_s += longint'($signed(lanes[i]));
      m_acc_u += longint'(lanes[i]);
    end
    m_cnt++;
    if (last) begin
      c = (m_cnt > 255) ? 8'hFF : CNT_W'(m_cnt);
      o = (m_acc_s > 64'sd2147483647) || (m_acc_s < -64'sd2147483648);
      e.ovf = o;
      e.cnt = c;
      e.sum = o ? ((m_acc_s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : m_acc_s[31:0];
      q_ss.push_back(e);
      o = (m_acc_u > 64'h0000_0000_FFFF_FFFF);
      e.ovf = o;
      e.sum = o ? 32'hFFFF_FFFF : m_acc_u[31:0];
      q_us.push_back(e);
      e.sum = m_acc_u[31:0];
      q_uw.push_back(e);
      model_clear();
    end
  endtask

  task automatic fill(input logic [WIDTH-1:0] v);
    for (int i = 0; i < N; i++) lanes[i] = v;
  endtask

  // Entered and left just after a rising edge; returns once the beat is taken.
  task automatic send(input logic last);
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_last  = last;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = ss_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", 64'(ok), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) model_accept(last);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (ss_valid) begin
        n = i;
        break;
      end
    end
    check("wait_valid_in_time", 64'(n != 0), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q_ss.size() == 0 && q_us.size() == 0 && q_uw.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_ss", 64'(q_ss.size()), 64'd0);
    check("drain_us", 64'(q_us.size()), 64'd0);
    check("drain_uw", 64'(q_uw.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; sum_ready = 1'b1;
    fill('0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_during_reset", 64'(ss_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("reset_sum_valid", 64'(ss_valid), 64'd0);
    check("reset_sum", 64'(ss_sum), 64'd0);
    check("reset_ovf", 64'(ss_ovf), 64'd0);
    check("reset_beat_cnt", 64'(ss_cnt), 64'd0);
    check("in_ready_after_reset", 64'(ss_ready), 64'd1);

    // Single beat of ones; result on the 6th edge counting the accepting one.
    fill(32'd1);
    send(1'b1);
    wait_valid(n);
    check("latency_edges_after_accept", 64'(n), 64'd5);

    fill('0); lanes[0] = 32'd1;      send(1'b1);
    fill('0); lanes[N-1] = 32'd1;    send(1'b1);
    fill(32'hFFFF_FFFF);             send(1'b1);
    fill('0); lanes[0] = 32'h7FFF_FFFF; lanes[1] = 32'h7FFF_FFFF; send(1'b1);
    for (int i = 0; i < N; i++) lanes[i] = (i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFD;
    send(1'b1);

    // Multi-beat packet followed back-to-back by a single-beat packet.
    fill(32'd1); send(1'b0); send(1'b0); send(1'b1);
    fill(32'd2); send(1'b1);
    // Bubbles inside a packet leave the running sum untouched.
    fill(32'd3); send(1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(1'b1);
    drain();

    // Output backpressure with a pending input beat held valid.
    sum_ready = 1'b0;
    fill(32'd4); send(1'b1);
    wait_valid(n);
    fill(32'd5);
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 64'(ss_ready), 64'd0);
      check("bp_sum_valid", 64'(ss_valid), 64'd1);
      check("bp_sum_stable", 64'(ss_sum), 64'(q_ss[0].sum));
    end
    sum_ready = 1'b1;
    send(1'b1);
    drain();

    // Global enable dropped for three cycles after the final beat.
    fill(32'd1); send(1'b0);
    fill(32'd6); send(1'b1);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    wait_valid(n);
    check("en_latency_edges", 64'(n + 3), 64'd8);
    drain();

    // Reset in mid-packet discards the in-flight beats.
    fill(32'd7); send(1'b0); send(1'b0);
    rst = 1'b1;
    #1;
    check("in_ready_forced_low_by_rst", 64'(ss_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    q_ss.delete(); q_us.delete(); q_uw.delete();
    check("midrst_ss_valid", 64'(ss_valid), 64'd0);
    check("midrst_ss_sum", 64'(ss_sum), 64'd0);
    check("midrst_us_valid", 64'(us_valid), 64'd0);
    check("midrst_uw_sum", 64'(uw_sum), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_stale_result", 64'(ss_valid), 64'd0);
    fill(32'd1); send(1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/accumulator_pipe.md
Name: accumulator_pipe

Overview:
- Parametrised, fully pipelined integer reduction accumulator; successor to the fixed 16x32 accumulator.
- Each accepted beat carries N lanes of WIDTH bits. The lanes are summed by a registered adder tree, and tree results are accumulated across beats until a beat tagged in_last.
- Adds a valid/ready stream handshake, multi-beat packets, signed/unsigned mode, saturation vs wrap, overflow flag and beat count.
- Sits between the multiply array and the activation stage of the BDPU datapath.

Parameters:
N, 16, lane count per beat; power of two, 2..64; LOG2N = log2(N)
WIDTH, 32, lane and result width in bits
SIGNED, 1, 1 = two's-complement lanes, 0 = unsigned
SATURATE, 1, 1 = clamp result to WIDTH range, 0 = wrap (truncate low WIDTH bits)
GUARD, 8, extra accumulator bits; ACC_W = WIDTH+LOG2N+GUARD
CNT_W, 8, width of beat counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
en  in  1  global enable; 0 freezes all state
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&&in_ready at clk edge
in_last  in  1  beat closes current packet
vals  in  N*WIDTH  lanes packed, lane 0 in MSBs [N*WIDTH-1 -: WIDTH]
sum  out  WIDTH  packet result
sum_valid  out  1  result valid, held until taken
sum_ready  in  1  consumer accepts result when sum_valid&&sum_ready
ovf  out  1  packet sum outside WIDTH range; qualified by sum_valid
beat_cnt  out  CNT_W  beats in packet; qualified by sum_valid

Behaviour:
- Reset (rst=1 at edge): all stage valid bits, accumulator, beat counter, sum, ovf and beat_cnt clear to 0; sum_valid=0. in_ready is forced 0 while rst=1.
- Stall rule: stall = !en || (sum_valid && !sum_ready). in_ready = !rst && !stall. When stalled, every pipeline register holds its value.
- Pipeline structure:
  - Stage 0 registers the N lanes, sign-extended (SIGNED=1) or zero-extended to ACC_W, plus valid and last.
  - Stages 1..LOG2N each halve the lane count with pairwise adds of adjacent lanes, registering valid and last.
  - Stage LOG2N+1 (accumulator): on a valid tree output, acc <= (first_beat ? 0 : acc) + tree, and cnt <= (first_beat ? 1 : cnt+1). first_beat is set after reset and after each last.
  - When the final beat arrives, the same edge loads sum/ovf/beat_cnt from acc+tree and sets sum_valid.
- Latency: sum_valid rises LOG2N+2 edges after the in_last beat is accepted, absent stall. For N=16 that is 6 cycles. Throughput is 1 beat/cycle.
- Result width:
  - ovf=1 if the ACC_W result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] (SIGNED) or above 2^WIDTH-1 (unsigned).
  - SATURATE=1: sum clamps to the nearest bound when ovf=1. SATURATE=0: sum = low WIDTH bits.
  - ovf is reported in both modes.
- Output handshake: sum_valid is cleared by sum_valid&&sum_ready unless a new final beat loads on the same edge, in which case it stays 1 with the new data. The output holds while sum_ready is low.
- Beat count: beat_cnt saturates at 2^CNT_W-1. Packets longer than 2^GUARD beats give an undefined sum.
- A single-beat packet (in_last on the first beat) is legal.
- Back-to-back packets need no idle cycle.
- Reset mid-packet discards all in-flight beats and any pending result. The next accepted beat starts a new packet.
- en=0 mid-packet resumes exactly where it stopped.
- in_valid=0 produces bubbles that do not disturb acc.

Test Plan:
- N=16, WIDTH=32, SIGNED=1: one beat of all lanes 0x00000001 with in_last -> sum=0x00000010, ovf=0, beat_cnt=1, 6 cycles after acceptance. Repeat with only lane 0 =1, then only lane 15 =1 -> sum=0x00000001 each.
- SIGNED=0: all lanes 0xFFFFFFFF, single beat -> with SATURATE=1: sum=0xFFFFFFFF, ovf=1; with SATURATE=0: sum=0xFFFFFFF0, ovf=1. SIGNED=1 with the same lanes -> sum=0xFFFFFFF0 (-16), ovf=0.
- SIGNED=1 mix: lanes 0x7FFFFFFF x2 plus 14 zeros -> SATURATE=1 gives sum=0x7FFFFFFF, ovf=1. Lanes alternating +5/-3 -> sum=0x00000010, ovf=0.
- Multi-beat: 3 consecutive beats of all-ones lanes (value 1), last on beat 3, immediately followed by a 1-beat packet of 2s -> results 0x30 (beat_cnt=3), then 0x20 (beat_cnt=1), on consecutive valid outputs.
- Backpressure: hold sum_ready=0 for 4 cycles after sum_valid while in_valid stays high -> in_ready=0, sum stable. Release -> next packet completes correctly, nothing lost or duplicated. en=0 for 3 mid-packet cycles -> same final sum, latency extended by 3.
- Reset mid-packet: accept 2 non-last beats, assert rst for 1 cycle -> sum_valid=0, sum=0. A subsequent single beat of ones -> sum=0x10, beat_cnt=1.
